alu_serial_rx: RTL and testbench
================================

ALU_SERIAL_RX -- requirements
Module: alu_serial_rx

Interface
REQ-001 The block SHALL have parameter: OP_BYTES, default 4, bytes per operand; operand width = 8*OP_BYTES; data words per packet = 2*OP_BYTES.
REQ-002 Port: clk  in  1  single clock; all sequential logic on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: din  in  1  serial data; stable at rising edge.
REQ-005 Port: enable_n  in  1  active-low word strobe; low for the bit cells of one word.
REQ-006 Port: b_data  out  8*OP_BYTES  operand B, first received.
REQ-007 Port: a_data  out  8*OP_BYTES  operand A, second received.
REQ-008 Port: ctl  out  8  payload of the control word.
REQ-009 Port: pkt_valid  out  1  one-cycle pulse; b_data/a_data/ctl hold a complete packet.
REQ-010 Port: err_frame  out  1  one-cycle pulse; malformed word.
REQ-011 Port: err_data  out  1  one-cycle pulse; wrong data-word count before control word.

Function
REQ-012 Word format SHALL be 10 bits, MSB first: bit0 start (must be 0), bit1 type (0 data, 1 control), bits2..9 payload byte MSB first.
REQ-013 din SHALL be sampled on each rising edge where enable_n==0; no sampling when enable_n==1.
REQ-014 Word FSM SHALL have states IDLE, SHIFT, DRAIN: IDLE->SHIFT on first sample with enable_n==0; SHIFT counts bits 0..9.
REQ-015 On the edge sampling bit 9, the word SHALL complete and the FSM SHALL enter DRAIN; DRAIN->IDLE on the first edge with enable_n==1.
REQ-016 Sampled start bit of 1 SHALL flag the word invalid; at completion err_frame pulses and the word is discarded.
REQ-017 enable_n returning high in SHIFT before bit 9 SHALL pulse err_frame on that edge, discard the word, go to IDLE.
REQ-018 enable_n still low in DRAIN (11th+ bit) SHALL pulse err_frame once on the first such edge, discard packet state, stay in DRAIN until enable_n high.
REQ-019 A completed valid data word SHALL shift its payload into a 16*OP_BYTES-bit packet register (new byte at LSB) and increment a data counter saturating at 2*OP_BYTES+1.
REQ-020 B SHALL be the first OP_BYTES data bytes (first byte = MSB); A the next OP_BYTES bytes (first = MSB).
REQ-021 A valid control word with data counter == 2*OP_BYTES SHALL, on its bit-9 edge, load b_data, a_data, ctl and pulse pkt_valid.
REQ-022 A valid control word with data counter != 2*OP_BYTES SHALL pulse err_data, leave b_data/a_data/ctl unchanged, no pkt_valid.
REQ-023 After any control word or err_frame, the data counter SHALL clear to 0.
REQ-024 Latency: pkt_valid/err_data high from the rising edge sampling bit 9 of the control word, for exactly one cycle.
REQ-025 Back-to-back words separated by one enable_n-high cycle SHALL be received without loss.
REQ-026 pkt_valid, err_data, err_frame SHALL be mutually exclusive in any cycle.
REQ-027 b_data, a_data, ctl SHALL hold their value between pkt_valid pulses.

Reset
REQ-028 rst_n low SHALL immediately force: FSM IDLE, bit and data counters 0, packet register 0, b_data/a_data/ctl 0, pkt_valid/err_frame/err_data 0.
REQ-029 Reset asserted mid-word or mid-packet SHALL abandon it without any pulse; after release, a word in progress (enable_n already low) SHALL be ignored until enable_n goes high.

Verification
REQ-030 Words 0x0_11,0x0_22,...,0x0_88 (data) then control 0x1_A5 -> b_data=0x11223344, a_data=0x55667788, ctl=0xA5, one pkt_valid pulse on control bit-9 edge.
REQ-031 Six data words then control -> err_data single pulse, outputs keep previous packet, next correct 8+1 packet accepted.
REQ-032 Data word with start bit 1 inside a packet -> err_frame pulse, counter cleared, following full 8+1 packet accepted.
REQ-033 enable_n high after 6 bits -> err_frame on that edge; enable_n low 12 cycles -> single err_frame, DRAIN until enable_n high.
REQ-034 rst_n pulsed low during 5th data word -> all outputs 0 at once, no pulses; subsequent full packet yields correct pkt_valid.
REQ-035 Two packets back-to-back, one idle cycle between words -> two pkt_valid pulses, second packet's values loaded.

Source files
------------

// File: rtl/alu_serial_rx.sv
// Serial word receiver that assembles two operands and a control byte
// into ALU packets, with framing and word-count error reporting.
module alu_serial_rx #(
    parameter int OP_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  enable_n,
    output logic [8*OP_BYTES-1:0] b_data,
    output logic [8*OP_BYTES-1:0] a_data,
    output logic [7:0]            ctl,
    output logic                  pkt_valid,
    output logic                  err_frame,
    output logic                  err_data
);

    localparam int W  = 8 * OP_BYTES;
    localparam int PW = 2 * W;
    localparam int NW = 2 * OP_BYTES;
    localparam int CW = $clog2(NW + 2);
    localparam logic [CW-1:0] FULL = CW'(NW);
    localparam logic [CW-1:0] SAT  = CW'(NW + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [3:0]      bit_cnt;
    logic [8:0]      sr;
    logic [CW-1:0]   data_cnt;
    logic [PW-1:0]   pkt;
    logic            armed;
    logic            drain_err;

    logic            sample;
    logic            last;
    logic            abort;
    logic            over;
    logic [9:0]      word;
    logic            bad_start;
    logic            data_ok;
    logic            ctl_ok;
    logic            fire;
    logic            ferr;
    logic            derr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (sample) state_nx = SHIFT;
            end
            SHIFT: begin
                if (enable_n) state_nx = IDLE;
                else if (last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (enable_n) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Word decode; a word only counts on the edge that samples bit 9.
    always_comb begin
        sample    = !enable_n &&
                    ((state == SHIFT) || ((state == IDLE) && armed));
        last      = (state == SHIFT) && !enable_n && (bit_cnt == 4'd9);
        abort     = (state == SHIFT) && enable_n;
        over      = (state == DRAIN) && !enable_n && !drain_err;
        word      = {sr, din};
        bad_start = last && word[9];
        data_ok   = last && !word[9] && !word[8];
        ctl_ok    = last && !word[9] && word[8];
        fire      = ctl_ok && (data_cnt == FULL);
        derr      = ctl_ok && (data_cnt != FULL);
        ferr      = abort || over || bad_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            sr        <= '0;
            armed     <= 1'b0;
            drain_err <= 1'b0;
        end else begin
            // A word already in flight at reset release is skipped.
            armed     <= armed | enable_n;
            drain_err <= (state == DRAIN) && (drain_err || over);
            if (sample) begin
                bit_cnt <= (state == IDLE) ? 4'd1 : bit_cnt + 4'd1;
                sr      <= {sr[7:0], din};
            end else begin
                bit_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_cnt <= '0;
            pkt      <= '0;
        end else begin
            if (ferr || ctl_ok) begin
                data_cnt <= '0;
            end else if (data_ok && (data_cnt != SAT)) begin
                data_cnt <= data_cnt + 1'b1;
            end
            if (over) begin
                pkt <= '0;
            end else if (data_ok) begin
                pkt <= {pkt[PW-9:0], word[7:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_data    <= '0;
            a_data    <= '0;
            ctl       <= '0;
            pkt_valid <= 1'b0;
            err_frame <= 1'b0;
            err_data  <= 1'b0;
        end else begin
            pkt_valid <= fire;
            err_frame <= ferr;
            err_data  <= derr;
            if (fire) begin
                b_data <= pkt[PW-1:W];
                a_data <= pkt[W-1:0];
                ctl    <= word[7:0];
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Randomized bench for alu_serial_rx with a word-level packet model.
module tb_alu_serial_rx;

    localparam int N  = 4;
    localparam int NW = 2 * N;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic        enable_n;
    logic [31:0] b_data;
    logic [31:0] a_data;
    logic [7:0]  ctl;
    logic        pkt_valid;
    logic        err_frame;
    logic        err_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_b = '0;
    logic [31:0] exp_a = '0;
    logic [7:0]  exp_ctl = '0;
    logic        exp_pv = 1'b0;
    logic        exp_fe = 1'b0;
    logic        exp_de = 1'b0;
    logic [7:0]  q[$];
    int          ndata = 0;

    alu_serial_rx #(.OP_BYTES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .enable_n  (enable_n),
        .b_data    (b_data),
        .a_data    (a_data),
        .ctl       (ctl),
        .pkt_valid (pkt_valid),
        .err_frame (err_frame),
        .err_data  (err_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Word-level packet semantics: bytes queue, count, outcome of control.
    function automatic void model_word(input logic [9:0] w);
        if (w[9]) begin
            exp_fe = 1'b1;
            ndata  = 0;
            q.delete();
        end else if (!w[8]) begin
            q.push_back(w[7:0]);
            if (q.size() > NW) void'(q.pop_front());
            ndata++;
        end else begin
            if (ndata == NW) begin
                exp_b = '0;
                exp_a = '0;
                for (int i = 0; i < N; i++) begin
                    exp_b = {exp_b[23:0], q[i]};
                    exp_a = {exp_a[23:0], q[N+i]};
                end
                exp_ctl = w[7:0];
                exp_pv  = 1'b1;
            end else begin
                exp_de = 1'b1;
            end
            ndata = 0;
            q.delete();
        end
    endfunction

    function automatic void model_ferr();
        exp_fe = 1'b1;
        ndata  = 0;
        q.delete();
    endfunction

    function automatic void model_reset();
        exp_b   = '0;
        exp_a   = '0;
        exp_ctl = '0;
        exp_pv  = 1'b0;
        exp_fe  = 1'b0;
        exp_de  = 1'b0;
        ndata   = 0;
        q.delete();
    endfunction

    task automatic tick(input logic en, input logic d);
        @(negedge clk);
        enable_n = en;
        din      = d;
        @(posedge clk);
        #1;
        exp_pv = 1'b0;
        exp_fe = 1'b0;
        exp_de = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w, input int nbits,
                             input int gap);
        for (int i = 0; i < nbits; i++) begin
            tick(1'b0, (i < 10) ? w[9-i] : 1'($urandom));
            if (i == 9) model_word(w);
            if (i == 10) model_ferr();
        end
        for (int g = 0; g < gap; g++) begin
            tick(1'b1, 1'($urandom));
            if (g == 0 && nbits < 10) model_ferr();
        end
    endtask

    task automatic send_pkt(input int ndat, input int gap);
        for (int i = 0; i < ndat; i++)
            send_word({2'b00, 8'($urandom)}, 10, gap);
        send_word({2'b01, 8'($urandom)}, 10, gap);
    endtask

    always @(negedge clk) begin
        chk("pkt_valid", 64'(pkt_valid), 64'(exp_pv));
        chk("err_frame", 64'(err_frame), 64'(exp_fe));
        chk("err_data",  64'(err_data),  64'(exp_de));
        chk("b_data",    64'(b_data),    64'(exp_b));
        chk("a_data",    64'(a_data),    64'(exp_a));
        chk("ctl",       64'(ctl),       64'(exp_ctl));
    end

    initial begin
        logic [9:0] w;
        rst_n    = 1'b0;
        enable_n = 1'b1;
        din      = 1'b0;
        repeat (3) tick(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick(1'b1, 1'b0);
        chk("reset_b",  64'(b_data), 64'h0);
        chk("reset_pv", 64'(pkt_valid), 64'h0);

        // Directed packet with hand-computed result
        for (int i = 1; i <= 8; i++)
            send_word({2'b00, 4'(i), 4'(i)}, 10, 1);
        send_word(10'h1A5, 10, 1);
        chk("lit_b",   64'(b_data), 64'h11223344);
        chk("lit_a",   64'(a_data), 64'h55667788);
        chk("lit_ctl", 64'(ctl),    64'hA5);
        chk("lit_model_b", 64'(exp_b), 64'h11223344);
        chk("lit_model_a", 64'(exp_a), 64'h55667788);

        // Short packet: err_data, outputs hold
        send_pkt(6, 1);
        chk("hold_b", 64'(b_data), 64'h11223344);
        chk("hold_ctl", 64'(ctl), 64'hA5);
        send_pkt(8, 1);

        // Bad start bit mid-packet
        for (int i = 0; i < 3; i++) send_word({2'b00, 8'($urandom)}, 10, 1);
        send_word({2'b10, 8'h5A}, 10, 1);
        send_pkt(8, 1);

        // Truncated word, then over-long word
        send_word({2'b00, 8'h77}, 6, 2);
        send_word({2'b00, 8'h66}, 12, 1);
        send_pkt(8, 2);

        // Reset during the 5th data word
        for (int i = 0; i < 4; i++) send_word({2'b00, 8'($urandom)}, 10, 1);
        w = {2'b00, 8'hC3};
        for (int i = 0; i < 5; i++) tick(1'b0, w[9-i]);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_b",   64'(b_data),    64'h0);
        chk("rst_a",   64'(a_data),    64'h0);
        chk("rst_ctl", 64'(ctl),       64'h0);
        chk("rst_pv",  64'(pkt_valid), 64'h0);
        model_reset();
        tick(1'b0, w[4]);
        tick(1'b0, w[3]);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 7; i < 10; i++) tick(1'b0, w[9-i]);
        tick(1'b1, 1'b0);
        send_pkt(8, 1);

        // Back-to-back packets, minimum gap
        send_pkt(8, 1);
        send_pkt(8, 1);

        // Random mix of good packets, wrong counts and framing faults
        for (int k = 0; k < 25; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                send_pkt(8, int'($urandom_range(1, 3)));
            end else if (r < 8) begin
                send_pkt(int'($urandom_range(0, 10)), 1);
            end else begin
                send_word({1'b0, 1'($urandom), 8'($urandom)},
                          int'($urandom_range(2, 13)),
                          int'($urandom_range(1, 2)));
            end
        end
        repeat (3) tick(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
